// File: rtl/rect_click_detect.sv
// Click detector for a rectangular screen region: pipelined hit test plus a press/hold/release
// FSM that yields a hover flag, a one-cycle click pulse and a sticky clicked flag.
module rect_click_detect #(
   parameter int unsigned MIN_PRESS = 4,
   parameter int unsigned CNT_W     = 4
) (
   input  logic        pclk,
   input  logic        rst,
   input  logic        enable,
   input  logic        clr,
   input  logic [11:0] mouse_xpos,
   input  logic [11:0] mouse_ypos,
   input  logic        mouse_left,
   input  logic [10:0] hstart,
   input  logic [10:0] vstart,
   input  logic [10:0] hlength,
   input  logic [10:0] vlength,
   output logic        hover,
   output logic        click_pulse,
   output logic        rect_clicked
);

   localparam int unsigned PW = 12;
   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0] MIN_CNT = CNT_W'(MIN_PRESS);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ARMED   = 2'd1,
      BLOCKED = 2'd2
   } state_t;

   logic [PW-1:0]    x_q, y_q;
   logic [10:0]      hs_q, vs_q, hl_q, vl_q;
   logic             btn1_q, btn2_q, btnp_q;
   logic             inside_q;
   logic [2:0]       vld_q;
   logic [PW-1:0]    hend_d, vend_d;
   logic             inside_d, press_d;
   state_t           state_q;
   logic [CNT_W-1:0] cnt_q;

   // Input capture (stage 1), hit/button stage (stage 2) and the previous stage-2 button.
   always_ff @(posedge pclk or posedge rst) begin
      if (rst) begin
         x_q      <= '0;
         y_q      <= '0;
         hs_q     <= '0;
         vs_q     <= '0;
         hl_q     <= '0;
         vl_q     <= '0;
         btn1_q   <= 1'b0;
         btn2_q   <= 1'b0;
         btnp_q   <= 1'b0;
         inside_q <= 1'b0;
         vld_q    <= '0;
      end else begin
         x_q      <= mouse_xpos;
         y_q      <= mouse_ypos;
         hs_q     <= hstart;
         vs_q     <= vstart;
         hl_q     <= hlength;
         vl_q     <= vlength;
         btn1_q   <= mouse_left;
         btn2_q   <= btn1_q;
         btnp_q   <= btn2_q;
         inside_q <= inside_d;
         vld_q    <= {vld_q[1:0], 1'b1};
      end
   end

   always_comb begin
      hend_d   = PW'(hs_q) + PW'(hl_q);
      vend_d   = PW'(vs_q) + PW'(vl_q);
      inside_d = (hl_q != '0) && (vl_q != '0) &&
                 (x_q >= PW'(hs_q)) && (x_q < hend_d) &&
                 (y_q >= PW'(vs_q)) && (y_q < vend_d);
   end

   // A button already held when the pipeline refills after reset must not look like a press.
   assign press_d = vld_q[2] && btn2_q && !btnp_q;

   always_ff @(posedge pclk or posedge rst) begin
      if (rst) begin
         state_q      <= IDLE;
         cnt_q        <= '0;
         hover        <= 1'b0;
         click_pulse  <= 1'b0;
         rect_clicked <= 1'b0;
      end else if (!enable) begin
         state_q      <= IDLE;
         cnt_q        <= '0;
         hover        <= 1'b0;
         click_pulse  <= 1'b0;
         rect_clicked <= 1'b0;
      end else begin
         hover       <= inside_q;
         click_pulse <= 1'b0;
         if (clr) begin
            rect_clicked <= 1'b0;
         end
         case (state_q)
            IDLE: begin
               if (press_d && inside_q) begin
                  state_q <= ARMED;
                  cnt_q   <= CNT_W'(1);
               end else if (press_d) begin
                  state_q <= BLOCKED;
               end
            end
            ARMED: begin
               if (btn2_q) begin
                  if (!inside_q) begin
                     state_q <= BLOCKED;
                     cnt_q   <= '0;
                  end else if (cnt_q != CNT_MAX) begin
                     cnt_q <= cnt_q + CNT_W'(1);
                  end
               end else begin
                  // Release; a valid click overrides a coincident clr.
                  state_q <= IDLE;
                  cnt_q   <= '0;
                  if (inside_q && (cnt_q >= MIN_CNT)) begin
                     click_pulse  <= 1'b1;
                     rect_clicked <= 1'b1;
                  end
               end
            end
            BLOCKED: begin
               if (!btn2_q) begin
                  state_q <= IDLE;
               end
            end
            default: begin
               state_q <= IDLE;
               cnt_q   <= '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_rect_click_detect.sv
// Self-checking bench for rect_click_detect: a cycle model pushes expected outputs to a
// scoreboard queue as stimulus is driven; they are popped and compared after each edge.
module tb_rect_click_detect;

   localparam int unsigned MIN_PRESS = 4;
   localparam int unsigned CNT_W     = 4;
   localparam int          CNT_SAT   = (1 << CNT_W) - 1;

   logic        pclk = 1'b0;
   logic        rst = 1'b1;
   logic        enable = 1'b1;
   logic        clr = 1'b0;
   logic [11:0] mouse_xpos = '0;
   logic [11:0] mouse_ypos = '0;
   logic        mouse_left = 1'b0;
   logic [10:0] hstart = 11'd380;
   logic [10:0] vstart = 11'd186;
   logic [10:0] hlength = 11'd300;
   logic [10:0] vlength = 11'd100;
   logic        hover, click_pulse, rect_clicked;

   rect_click_detect #(.MIN_PRESS(MIN_PRESS), .CNT_W(CNT_W)) dut (
      .pclk(pclk), .rst(rst), .enable(enable), .clr(clr),
      .mouse_xpos(mouse_xpos), .mouse_ypos(mouse_ypos), .mouse_left(mouse_left),
      .hstart(hstart), .vstart(vstart), .hlength(hlength), .vlength(vlength),
      .hover(hover), .click_pulse(click_pulse), .rect_clicked(rect_clicked)
   );

   always #5 pclk = ~pclk;

   typedef struct packed {
      logic        v;
      logic [11:0] x, y;
      logic        b;
      logic [10:0] hs, vs, hl, vl;
   } smp_t;

   typedef struct packed {
      logic hov;
      logic pls;
      logic clk;
   } exp_t;

   smp_t hist[$];
   exp_t sb[$];

   int n_err = 0;
   int n_chk = 0;
   int n_cyc = 0;
   int n_pulse = 0;

   // Model state: 0 idle, 1 armed, 2 blocked.
   int   m_st = 0;
   int   m_cnt = 0;
   logic m_hov = 1'b0, m_pls = 1'b0, m_clk = 1'b0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, n_cyc, got, exp);
      end
   endtask

   function automatic logic hit(input smp_t s);
      int xe, ye;
      xe = int'(s.hs) + int'(s.hl);
      ye = int'(s.vs) + int'(s.vl);
      return s.v && (s.hl != 0) && (s.vl != 0) &&
             (int'(s.x) >= int'(s.hs)) && (int'(s.x) < xe) &&
             (int'(s.y) >= int'(s.vs)) && (int'(s.y) < ye);
   endfunction

   // Expected outputs after this edge: position/button seen two edges ago, enable/clr now.
   task automatic model();
      smp_t s, h2, h3;
      logic ins, b, press;
      s    = '0;
      s.v  = !rst;
      s.x  = mouse_xpos;
      s.y  = mouse_ypos;
      s.b  = mouse_left;
      s.hs = hstart;
      s.vs = vstart;
      s.hl = hlength;
      s.vl = vlength;
      if (rst) hist.delete();
      hist.push_front(s);
      if (hist.size() > 4) void'(hist.pop_back());
      h2 = (hist.size() > 2) ? hist[2] : '0;
      h3 = (hist.size() > 3) ? hist[3] : '0;
      ins   = hit(h2);
      b     = h2.v && h2.b;
      press = h2.v && h3.v && h2.b && !h3.b;
      if (rst || !enable) begin
         m_st = 0; m_cnt = 0; m_hov = 0; m_pls = 0; m_clk = 0;
      end else begin
         m_hov = ins;
         m_pls = 0;
         if (clr) m_clk = 0;
         case (m_st)
            0: if (press) begin
                  if (ins) begin m_st = 1; m_cnt = 1; end
                  else m_st = 2;
               end
            1: if (b) begin
                  if (!ins) m_st = 2;
                  else if (m_cnt < CNT_SAT) m_cnt++;
               end else begin
                  if (ins && m_cnt >= int'(MIN_PRESS)) begin m_pls = 1; m_clk = 1; end
                  m_st = 0;
               end
            default: if (!b) m_st = 0;
         endcase
      end
      sb.push_back('{hov: m_hov, pls: m_pls, clk: m_clk});
   endtask

   task automatic step();
      exp_t e;
      model();
      @(posedge pclk);
      @(negedge pclk);
      n_cyc++;
      if (click_pulse) n_pulse++;
      e = sb.pop_front();
      chk("hover", 32'(hover), 32'(e.hov));
      chk("click_pulse", 32'(click_pulse), 32'(e.pls));
      chk("rect_clicked", 32'(rect_clicked), 32'(e.clk));
   endtask

   task automatic steps(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   task automatic press_for(input int n);
      mouse_left = 1'b1;
      steps(n);
      mouse_left = 1'b0;
      steps(6);
   endtask

   task automatic at(input int x, input int y);
      mouse_xpos = 12'(x);
      mouse_ypos = 12'(y);
   endtask

   int p0;

   initial begin
      // Reset state
      steps(2);
      chk("reset_hover", 32'(hover), 32'd0);
      chk("reset_clicked", 32'(rect_clicked), 32'd0);
      rst = 1'b0;
      steps(3);

      // Basic click, 10-cycle hold; pulse lands 3 edges after the release input
      at(500, 200);
      steps(3);
      p0 = n_pulse;
      mouse_left = 1'b1;
      steps(10);
      mouse_left = 1'b0;
      steps(2);
      chk("no_pulse_yet", 32'(click_pulse), 32'd0);
      step();
      chk("pulse_at_3", 32'(click_pulse), 32'd1);
      steps(4);
      chk("click_pulses", 32'(n_pulse - p0), 32'd1);
      chk("sticky", 32'(rect_clicked), 32'd1);
      chk("hover_in", 32'(hover), 32'd1);

      // clr with no click clears the flag at the next edge
      clr = 1'b1;
      step();
      clr = 1'b0;
      chk("clr_clears", 32'(rect_clicked), 32'd0);
      steps(2);

      // Boundary hover points
      at(679, 285); steps(3); chk("hov_679_285", 32'(hover), 32'd1);
      at(680, 285); steps(3); chk("hov_680_285", 32'(hover), 32'd0);
      at(379, 200); steps(3); chk("hov_379_200", 32'(hover), 32'd0);
      at(380, 186); steps(3); chk("hov_380_186", 32'(hover), 32'd1);
      at(680, 286); steps(3); chk("hov_680_286", 32'(hover), 32'd0);
      hlength = 11'd0;
      at(500, 200); steps(3); chk("hov_hl0", 32'(hover), 32'd0);
      at(380, 186); steps(3); chk("hov_hl0_corner", 32'(hover), 32'd0);
      hlength = 11'd300;
      at(500, 200); steps(3);

      // Short presses: below the threshold, just below, and exactly at it
      p0 = n_pulse; press_for(2); chk("short2", 32'(n_pulse - p0), 32'd0);
      chk("short2_flag", 32'(rect_clicked), 32'd0);
      p0 = n_pulse; press_for(3); chk("short3", 32'(n_pulse - p0), 32'd0);
      p0 = n_pulse; press_for(4); chk("press4", 32'(n_pulse - p0), 32'd1);
      clr = 1'b1; step(); clr = 1'b0; steps(2);

      // Drag out and back in
      p0 = n_pulse;
      mouse_left = 1'b1;
      steps(2); at(700, 200); steps(3); at(500, 200); steps(6);
      mouse_left = 1'b0;
      steps(6);
      chk("drag_out", 32'(n_pulse - p0), 32'd0);

      // Press outside, drag in, release inside
      at(100, 100); steps(3);
      p0 = n_pulse;
      mouse_left = 1'b1;
      steps(2); at(500, 200); steps(6);
      mouse_left = 1'b0;
      steps(6);
      chk("drag_in", 32'(n_pulse - p0), 32'd0);

      // Geometry moves away mid-press
      p0 = n_pulse;
      mouse_left = 1'b1;
      steps(3); hstart = 11'd600; steps(5);
      mouse_left = 1'b0;
      steps(6);
      chk("geom_move", 32'(n_pulse - p0), 32'd0);
      hstart = 11'd380; steps(3);

      // clr coincident with the click-completion edge: set wins
      p0 = n_pulse;
      mouse_left = 1'b1;
      steps(6);
      mouse_left = 1'b0;
      steps(2);
      clr = 1'b1;
      step();
      clr = 1'b0;
      chk("clr_vs_click", 32'(rect_clicked), 32'd1);
      chk("clr_vs_click_pulse", 32'(click_pulse), 32'd1);
      steps(3);
      clr = 1'b1; step(); clr = 1'b0; steps(2);

      // Async reset while armed; button kept held after reset, then released
      p0 = n_pulse;
      mouse_left = 1'b1;
      steps(4);
      #2 rst = 1'b1;
      #1 chk("async_rst_hover", 32'(hover), 32'd0);
      steps(2);
      rst = 1'b0;
      steps(6);
      mouse_left = 1'b0;
      steps(6);
      chk("rst_no_click", 32'(n_pulse - p0), 32'd0);
      chk("rst_flag", 32'(rect_clicked), 32'd0);

      // Click, then drop enable: flag clears; re-enable with button held gives no click
      press_for(5);
      chk("en_pre_click", 32'(rect_clicked), 32'd1);
      enable = 1'b0;
      step();
      chk("en_low_clears", 32'(rect_clicked), 32'd0);
      chk("en_low_hover", 32'(hover), 32'd0);
      p0 = n_pulse;
      mouse_left = 1'b1;
      steps(4);
      enable = 1'b1;
      steps(6);
      mouse_left = 1'b0;
      steps(6);
      chk("en_held_no_click", 32'(n_pulse - p0), 32'd0);
      chk("en_held_flag", 32'(rect_clicked), 32'd0);

      // Fresh press after re-enable clicks normally
      p0 = n_pulse; press_for(4); chk("en_fresh", 32'(n_pulse - p0), 32'd1);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule

// File: doc/rect_click_detect.md
Name: rect_click_detect

Overview:
- Upstream stage of the game state machine: turns raw mouse position and left-button level into the `rect_clicked_play` level that the state machine consumes.
- The state machine drives the rectangle geometry (hstart/vstart/hlength/vlength) back into this block.
- A click is registered only when the button is pressed inside the rectangle, held for a minimum time, and released still inside.
- Also provides a hover flag and a one-cycle click pulse for UI highlighting.

Parameters:
- MIN_PRESS, 4, minimum cycles the button must stay pressed inside the rectangle for a valid click.
- CNT_W, 4, width of the press-length counter; must satisfy 2^CNT_W-1 >= MIN_PRESS.

Ports:
- pclk  in  1  pixel clock, all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- enable  in  1  detector active; low forces the FSM to IDLE and clears all outputs.
- clr  in  1  synchronous one-cycle clear of the sticky rect_clicked flag.
- mouse_xpos  in  12  pointer x.
- mouse_ypos  in  12  pointer y.
- mouse_left  in  1  left button level, 1 = pressed.
- hstart  in  11  rectangle left edge.
- vstart  in  11  rectangle top edge.
- hlength  in  11  rectangle width; 0 = rectangle disabled.
- vlength  in  11  rectangle height; 0 = rectangle disabled.
- hover  out  1  registered: pointer inside the rectangle.
- click_pulse  out  1  one-cycle pulse per valid click.
- rect_clicked  out  1  sticky click flag; connects to the state machine's rect_clicked_play.

Behaviour:
- Reset: asynchronous, active-high. All registers clear; FSM = IDLE; hover = 0, click_pulse = 0, rect_clicked = 0, counter = 0.

Pipeline:
- Stage 1 registers x, y, button and the geometry at edge k.
- Stage 2 registers `inside` and the delayed button at edge k+1.
- FSM and outputs update at edge k+2, so input-to-output latency is 3 edges.
- hover is the stage-2 `inside` value.

Hit test:
- inside = (x >= hstart) && (x < hstart+hlength) && (y >= vstart) && (y < vstart+vlength).
- Sums are computed at 12 bits with no truncation; geometry is zero-extended to 12 bits.
- hlength == 0 or vlength == 0 forces inside = 0.

Press detection:
- press = stage-2 button rising edge; release = stage-2 button falling edge.

FSM states:
- IDLE:
  - press && inside -> ARMED, counter = 1.
  - press && !inside -> BLOCKED.
- ARMED:
  - Counter increments each cycle while the button is held, saturating at 2^CNT_W-1.
  - !inside while held -> BLOCKED (drag-out cancels the click).
  - release && inside && counter >= MIN_PRESS -> IDLE, with click_pulse = 1 for one cycle and rect_clicked set.
  - release with counter < MIN_PRESS -> IDLE, no click.
- BLOCKED: release -> IDLE. Pointer re-entry while held does not re-arm.

Sticky flag:
- rect_clicked holds at 1 until clr, !enable, or reset.
- If clr and a valid click occur in the same cycle, the set wins and rect_clicked stays 1.

enable low:
- Synchronous: at the next edge FSM = IDLE and counter, click_pulse and rect_clicked = 0.
- hover also reads 0; the pipeline keeps sampling.
- When enable returns high with the button already held, the block sees no press edge and stays IDLE until a fresh press.

Geometry change mid-press:
- New geometry takes effect through the pipeline.
- If the pointer is then outside while ARMED -> BLOCKED.

Asynchronous reset mid-press:
- FSM returns to IDLE; a subsequent release produces no click.

Test Plan:
- Rectangle 380/186/300/100. Pointer (500,200): press, hold 10 cycles, release -> click_pulse high exactly 1 cycle at 3 edges after release; rect_clicked = 1 and stays 1; hover = 1.
- Boundary: pointer (679,285) -> hover = 1; (680,285) -> 0; (379,200) -> 0; (380,186) -> 1. Same rectangle with hlength = 0 -> hover = 0 everywhere.
- Short press: 2-cycle press at (500,200) with MIN_PRESS = 4 -> no click_pulse, rect_clicked stays 0. 4-cycle press -> click registered.
- Drag-out: press at (500,200), move to (700,200) while held, move back, release -> no click.
  - Press at (100,100), drag into the rectangle, release inside -> no click.
- clr pulse with no click -> rect_clicked falls to 0 at the next edge. clr coincident with a click-completion cycle -> rect_clicked = 1.
- Reset and enable: asserting rst while ARMED, then release -> outputs 0, no pulse. Dropping enable after a click clears rect_clicked; raising enable with the button held, then release -> no click.
